// File: rtl/multiport_shared_memory.sv
// Shared single-bank memory with N requester ports, per-word coherency tags,
// round-robin or fixed-priority arbitration and a power-on initialisation sweep.
module multiport_shared_memory #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int MEM_DEPTH  = 16384,
    parameter int RR_MODE    = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            gnt,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [1:0]                      rstate,
    output logic                            err,
    output logic                            busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [MW-1:0]       PTR_LAST  = MW'(MEM_DEPTH - 1);
    localparam logic [PW-1:0]       LAST_INIT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        COH_I = 2'b00,
        COH_M = 2'b01,
        COH_S = 2'b10
    } coh_e;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [MW-1:0]         ptr_q;
    logic [PW-1:0]         last_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [1:0]            coh [MEM_DEPTH];

    logic                  run;
    logic                  init_we;
    logic [MW:0]           ptr_inc;
    logic [DATA_WIDTH-1:0] init_data;

    logic [NUM_PORTS-1:0]  elig;
    logic [PW-1:0]         rr_start;
    logic                  win_valid;
    logic [PW-1:0]         win_idx;
    logic [NUM_PORTS-1:0]  win_oh;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;
    logic                  in_range;
    logic [MW-1:0]         mem_idx;
    logic                  acc_wr;
    logic                  acc_rd_upd;

    // Port index "start + k" wrapped into 0..NUM_PORTS-1.
    function automatic logic [PW-1:0] wrap_idx(
        input logic [PW-1:0] s,
        input int            k
    );
        int t;
        t = int'(s) + k;
        if (t >= NUM_PORTS) begin
            t = t - NUM_PORTS;
        end
        return PW'(t);
    endfunction

    // FSM state and sweep pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                ptr_q <= ptr_q + MW'(1);
            end
        end
    end

    // Leave INIT once the last word has been swept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM outputs: busy flag, sweep write strobe and run enable.
    always_comb begin
        busy    = (state_q == ST_INIT);
        run     = (state_q == ST_RUN);
        init_we = reset_n && (state_q == ST_INIT);
    end

    assign ptr_inc   = {1'b0, ptr_q} + (MW + 1)'(1);
    assign init_data = DATA_WIDTH'(ptr_inc);

    // A port is masked during its own grant cycle.
    assign elig = run ? (req & ~gnt) : '0;

    assign rr_start = (RR_MODE != 0)
                    ? ((last_q == LAST_INIT) ? '0 : last_q + PW'(1))
                    : '0;

    // Pick the first eligible port searching upward from rr_start.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (elig[wrap_idx(rr_start, k)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_idx(rr_start, k);
            end
        end
    end

    assign win_oh = NUM_PORTS'(1) << win_idx;

    // Route only the winning port's request fields to the memory.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (win_idx == PW'(k)) begin
                sel_addr  = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = we[k];
            end
        end
    end

    assign in_range = ({1'b0, sel_addr} < DEPTH_L);
    assign mem_idx  = sel_addr[MW-1:0];

    assign acc_wr     = reset_n && win_valid && in_range && sel_we;
    assign acc_rd_upd = reset_n && win_valid && in_range && !sel_we
                     && (coh[mem_idx] == COH_I);

    // Storage: sweep fill, granted writes, and I->S on first read.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[ptr_q] <= init_data;
            coh[ptr_q] <= COH_I;
        end else if (acc_wr) begin
            mem[mem_idx] <= sel_wdata;
            coh[mem_idx] <= COH_M;
        end else if (acc_rd_upd) begin
            coh[mem_idx] <= COH_S;
        end
    end

    // Registered response: grant, read data, prior tag, range error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt    <= '0;
            rvalid <= '0;
            rdata  <= '0;
            rstate <= COH_I;
            err    <= 1'b0;
            last_q <= LAST_INIT;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            err    <= 1'b0;
            if (win_valid) begin
                gnt    <= win_oh;
                last_q <= win_idx;
                err    <= !in_range;
                rstate <= in_range ? coh[mem_idx] : COH_I;
                if (!sel_we) begin
                    rvalid <= win_oh;
                    rdata  <= in_range ? mem[mem_idx] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_shared_memory.sv
// Bench for multiport_shared_memory: table of single-port transactions
// through a scoreboard, plus arbitration, hazard and reset sequences.
module tb_multiport_shared_memory;

    localparam int NP       = 4;
    localparam int DW       = 16;
    localparam int AW       = 14;
    localparam int DEPTH    = 1000;
    localparam int DEPTH_FP = 64;
    localparam int NVEC     = 14;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     req;
    logic [NP-1:0]     req_fp;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;

    logic [NP-1:0]     gnt;
    logic [NP-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rstate;
    logic              err;
    logic              busy;

    logic [NP-1:0]     gnt_fp;
    logic [NP-1:0]     rvalid_fp;
    logic [DW-1:0]     rdata_fp;
    logic [1:0]        rstate_fp;
    logic              err_fp;
    logic              busy_fp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int port;
        bit wr;
        int a;
        int wd;
        int rd;
        int rs;
        int er;
    } vec_t;

    typedef struct {
        int port;
        bit wr;
        int rd;
        int rs;
        int er;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];

    always #5 clk = ~clk;

    multiport_shared_memory #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH),
        .RR_MODE   (1)
    ) u_rr (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rstate (rstate),
        .err    (err),
        .busy   (busy)
    );

    multiport_shared_memory #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH_FP),
        .RR_MODE   (0)
    ) u_fp (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req_fp),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt_fp),
        .rvalid (rvalid_fp),
        .rdata  (rdata_fp),
        .rstate (rstate_fp),
        .err    (err_fp),
        .busy   (busy_fp)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle; compare any grant against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (gnt !== '0) begin
            if (sb.size() == 0) begin
                check("spurious_gnt", 32'(gnt), 32'd0);
            end else begin
                e = sb.pop_front();
                check("gnt", 32'(gnt), 32'd1 << e.port);
                check("rvalid", 32'(rvalid), e.wr ? 32'd0 : (32'd1 << e.port));
                if (!e.wr) begin
                    check("rdata", 32'(rdata), 32'(e.rd));
                end
                check("rstate", 32'(rstate), 32'(e.rs));
                check("err", 32'(err), 32'(e.er));
            end
        end else begin
            check("idle_rvalid", 32'(rvalid), 32'd0);
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        req[v.port]            = 1'b1;
        we[v.port]             = v.wr;
        addr[v.port*AW +: AW]  = AW'(v.a);
        wdata[v.port*DW +: DW] = DW'(v.wd);
        e = '{v.port, v.wr, v.rd, v.rs, v.er};
        sb.push_back(e);
    endtask

    task automatic do_txn(input vec_t v);
        drive(v);
        drain(10);
        req = '0;
        we  = '0;
    endtask

    // Count clock edges until busy falls; no grant may appear meanwhile.
    task automatic wait_init(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            check("init_gnt", 32'(gnt), 32'd0);
        end while (busy && n < 3000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   gaps;
        vec_t v;
        exp_t e;

        vecs[0]  = '{0, 1'b0,    5, 0,      6,      0, 0};
        vecs[1]  = '{0, 1'b0,    5, 0,      6,      2, 0};
        vecs[2]  = '{2, 1'b1,  100, 'hBEEF, 0,      0, 0};
        vecs[3]  = '{0, 1'b0,  100, 0,      'hBEEF, 1, 0};
        vecs[4]  = '{1, 1'b0, 1000, 0,      0,      0, 1};
        vecs[5]  = '{3, 1'b1, 1000, 'hDEAD, 0,      0, 1};
        vecs[6]  = '{1, 1'b0, 1000, 0,      0,      0, 1};
        vecs[7]  = '{3, 1'b1, 1029, 'h1111, 0,      0, 1};
        vecs[8]  = '{2, 1'b0,    5, 0,      6,      2, 0};
        vecs[9]  = '{1, 1'b0,  999, 0,      1000,   0, 0};
        vecs[10] = '{1, 1'b1,    0, 'h1234, 0,      0, 0};
        vecs[11] = '{2, 1'b0,    0, 0,      'h1234, 1, 0};
        vecs[12] = '{0, 1'b1,  999, 'h55AA, 0,      2, 0};
        vecs[13] = '{3, 1'b0,  999, 0,      'h55AA, 1, 0};

        reset_n = 1'b0;
        req     = '0;
        req_fp  = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;

        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rstate", 32'(rstate), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Request held through the sweep must stay pending until RUN.
        v = '{2, 1'b0, 50, 0, 51, 0, 0};
        drive(v);
        #2 reset_n = 1'b1;
        wait_init(n);
        check("busy_cycles", 32'(n), 32'(DEPTH));
        drain(10);
        req = '0;

        for (int i = 0; i < NVEC; i++) begin
            do_txn(vecs[i]);
        end

        // All ports reading back-to-back: strict 0,1,2,3 rotation.
        req = '1;
        we  = '0;
        for (int p = 0; p < NP; p++) begin
            addr[p*AW +: AW] = AW'(10 + p);
        end
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                e = '{p, 1'b0, 11 + p, (r == 0) ? 0 : 2, 0};
                sb.push_back(e);
            end
        end
        gaps = 0;
        n    = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
            if (gnt == '0) gaps++;
        end
        req = '0;
        check("rr_gaps", 32'(gaps), 32'd0);
        check("rr_cycles", 32'(n), 32'd12);
        tick();

        // Fixed priority: ports 1 and 3 alternate via grant masking.
        check("fp_busy", 32'(busy_fp), 32'd0);
        addr[1*AW +: AW] = AW'(20);
        addr[3*AW +: AW] = AW'(21);
        req_fp = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fp_gnt", 32'(gnt_fp), (i % 2 == 0) ? 32'h2 : 32'h8);
            check("fp_rvalid", 32'(rvalid_fp), (i % 2 == 0) ? 32'h2 : 32'h8);
            check("fp_rdata", 32'(rdata_fp), (i % 2 == 0) ? 32'd21 : 32'd22);
            check("fp_rstate", 32'(rstate_fp), (i < 2) ? 32'd0 : 32'd2);
        end
        req_fp = '0;
        @(negedge clk);

        // Write then immediate read of the same word on the next cycle.
        addr[0*AW +: AW]  = AW'(30);
        addr[1*AW +: AW]  = AW'(30);
        wdata[0*DW +: DW] = 16'hCAFE;
        we                = 4'b0001;
        req_fp            = 4'b0011;
        @(negedge clk);
        check("haz_wr_gnt", 32'(gnt_fp), 32'h1);
        check("haz_wr_rvalid", 32'(rvalid_fp), 32'h0);
        check("haz_wr_rstate", 32'(rstate_fp), 32'd0);
        req_fp[0] = 1'b0;
        we        = '0;
        @(negedge clk);
        check("haz_rd_gnt", 32'(gnt_fp), 32'h2);
        check("haz_rd_rvalid", 32'(rvalid_fp), 32'h2);
        check("haz_rd_rdata", 32'(rdata_fp), 32'hCAFE);
        check("haz_rd_rstate", 32'(rstate_fp), 32'd1);
        req_fp = '0;
        tick();

        // Reset while a grant is visible: outputs clear at once.
        v = '{0, 1'b0, 5, 0, 6, 2, 0};
        do_txn(v);
        check("pre_rst_gnt", 32'(gnt), 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b1;
        wait_init(n);
        check("busy_cycles_2", 32'(n), 32'(DEPTH));
        @(negedge clk);

        // Sweep restarted: word 5 is back to 6 with tag I.
        v = '{0, 1'b0, 5, 0, 6, 0, 0};
        do_txn(v);
        v = '{1, 1'b0, 100, 0, 101, 0, 0};
        do_txn(v);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiport_shared_memory.md
MULTIPORT_SHARED_MEMORY -- requirements
Module: multiport_shared_memory

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of requester ports (legal 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the word width in bits.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 14, giving the per-port address width.
REQ-004 The block SHALL have parameter MEM_DEPTH, default 16384, giving the number of words (<= 2**ADDR_WIDTH).
REQ-005 The block SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-008 The block SHALL have port req, input, NUM_PORTS bits: per-port access request, held until granted.
REQ-009 The block SHALL have port we, input, NUM_PORTS bits: per-port 1 = write, 0 = read; qualified by req.
REQ-010 The block SHALL have port addr, input, NUM_PORTS*ADDR_WIDTH bits: port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 The block SHALL have port wdata, input, NUM_PORTS*DATA_WIDTH bits: port p uses slice [p*DATA_WIDTH +: DATA_WIDTH].
REQ-012 The block SHALL have port gnt, output, NUM_PORTS bits: one-hot, one-cycle acceptance pulse.
REQ-013 The block SHALL have port rvalid, output, NUM_PORTS bits: one-hot, one-cycle read-data-valid pulse.
REQ-014 The block SHALL have port rdata, output, DATA_WIDTH bits: shared read data, meaningful only while any rvalid bit is high.
REQ-015 The block SHALL have port rstate, output, 2 bits: coherency state of the accessed word before the access (I=00, M=01, S=10); valid with gnt.
REQ-016 The block SHALL have port err, output, 1 bit: one-cycle pulse, coincident with gnt, for an out-of-range address.
REQ-017 The block SHALL have port busy, output, 1 bit: high while initialisation is in progress.

Function
REQ-018 Control FSM states SHALL be INIT and RUN; reset enters INIT with sweep pointer 0.
REQ-019 In INIT, each cycle SHALL write memory[ptr] = ptr+1 (truncated to DATA_WIDTH) and coherency[ptr] = I, then increment ptr; after ptr = MEM_DEPTH-1 the FSM SHALL go to RUN.
REQ-020 busy SHALL be 1 in INIT and 0 in RUN; no gnt SHALL be issued in INIT, and requests SHALL remain pending.
REQ-021 In RUN, at each rising edge the block SHALL select at most one winner among eligible ports, where eligible = req & ~gnt, masking a port during its own gnt cycle.
REQ-022 RR_MODE=1: search SHALL start at (last_winner+1) mod NUM_PORTS; last_winner resets to NUM_PORTS-1, so port 0 has first priority.
REQ-023 RR_MODE=0: the lowest-indexed eligible port SHALL win.
REQ-024 gnt[w] SHALL be high in the cycle after the winning edge, for exactly one cycle.
REQ-025 Write: at the winning edge, memory[addr] SHALL take wdata and coherency[addr] SHALL become M; rvalid SHALL stay 0.
REQ-026 Read: at the winning edge, rdata SHALL register memory[addr], rvalid[w] SHALL pulse together with gnt[w], and coherency I SHALL become S while M and S are unchanged.
REQ-027 addr >= MEM_DEPTH: no memory or coherency update; a read SHALL return rdata = 0 with rvalid; err SHALL pulse.
REQ-028 A read of an address written in the previous transaction SHALL return the new data; there is no bypass hazard.
REQ-029 Per-port throughput SHALL be one access per 2 cycles; aggregate throughput SHALL be one access per cycle when at least 2 ports request.
REQ-030 Changes to the inputs of a non-winning port SHALL NOT affect that cycle's access.

Reset
REQ-031 On reset_n low, immediately and asynchronously: gnt=0, rvalid=0, rdata=0, rstate=00, err=0, busy=1, FSM=INIT, ptr=0, last_winner=NUM_PORTS-1.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL abandon any in-flight access and restart the sweep from 0 once reset_n deasserts.

Verification
REQ-033 Reset then idle -> busy high for exactly MEM_DEPTH cycles; afterwards a read of address 5 returns 6 with rstate=00, and a second read returns rstate=10.
REQ-034 All 4 ports request reads continuously with RR_MODE=1 -> grant order 0,1,2,3,0,... with no gaps and each rvalid coincident with its gnt.
REQ-035 RR_MODE=0, ports 1 and 3 request reads continuously -> port 1 granted every other cycle; port 3 is granted only in port 1's masked cycles.
REQ-036 Port 2 writes 16'hBEEF to address 100, then port 0 reads address 100 -> rdata=16'hBEEF, the read's rstate=01, and the write's rstate=00.
REQ-037 MEM_DEPTH=1000, port 1 reads address 1000 -> err pulse, rdata=0, rvalid[1]=1; a write to 1000 leaves memory unchanged.
REQ-038 reset_n pulsed low while gnt is high -> gnt drops within the same cycle, busy=1, and the sweep restarts at 0.
